regbank_wr16: RTL and testbench

- Write side of the 16 x 16-bit register bank. It demultiplexes one 16-bit write per cycle into one of 16 storage words.
- All words are presented as one flattened 256-bit bus. The 16:1 read mux consumes this bus.
- Also provides a sequenced bank clear: one word per cycle, with the write port stalled while the clear runs.

---
 rtl/regbank_wr16_pkg.sv | 14 +
 rtl/regbank_word.sv | 26 ++
 rtl/regbank_wr16.sv | 91 +++++++++
 tb/tb_regbank_wr16.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/regbank_wr16_pkg.sv
// Shared constants for the 16x16 register bank.
// Read mux and write side both import this package.
package regbank_wr16_pkg;

  localparam int REGBANK_WIDTH = 16;
  localparam int REGBANK_DEPTH = 16;
  localparam int REGBANK_AW    = 4;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_t;

endpackage

// File: rtl/regbank_word.sv
// One storage word of the bank.
// Sync clear wins over write enable.
import regbank_wr16_pkg::*;

module regbank_word #(
  parameter int WIDTH = REGBANK_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regbank_wr16.sv
// Write side of the register bank: address decode,
// sequenced one-word-per-cycle clear, flattened output.
import regbank_wr16_pkg::*;

module regbank_wr16 #(
  parameter int WIDTH     = REGBANK_WIDTH,
  parameter int DEPTH     = REGBANK_DEPTH,
  parameter int ZERO_REG0 = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clr,
  output logic                   busy,
  output logic                   clr_done,
  output logic [WIDTH*DEPTH-1:0] out
);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] cnt;
  logic          last;
  logic          clearing;
  logic          accept;
  logic          done_nx;

  assign last = (cnt == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (clr) state_nx = ST_CLEARING;
      ST_CLEARING: if (last) state_nx = ST_IDLE;
    endcase
  end

  // done is registered one cycle early so it lines up
  // with the cycle that clears the last word
  always_comb begin
    wr_ready = (state == ST_IDLE);
    busy     = (state == ST_CLEARING);
    clearing = (state == ST_CLEARING);
    accept   = wr_valid && wr_ready;
    done_nx  = clearing && (cnt == AW'(DEPTH - 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= done_nx;
      if (clearing && !last) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam bit RO = (ZERO_REG0 != 0) && (i == 0);
    logic we;
    logic wclr;
    assign we   = accept && (wr_addr == AW'(i)) && !RO;
    assign wclr = clearing && (cnt == AW'(i));
    regbank_word #(
      .WIDTH(WIDTH)
    ) u_word (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we),
      .clr  (wclr),
      .d    (wr_data),
      .q    (out[WIDTH*i +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regbank_wr16.sv
// Bench for regbank_wr16: vector table, directed
// clear sequences and random traffic against a model.
module tb_regbank_wr16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_valid;
  logic         wr_ready;
  logic [3:0]   wr_addr;
  logic [15:0]  wr_data;
  logic         clr;
  logic         busy;
  logic         clr_done;
  logic [255:0] out;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] mw [16];
  int          clr_left;

  typedef struct {
    logic        v;
    logic [3:0]  a;
    logic [15:0] d;
    logic [3:0]  ca;
    logic [15:0] ce;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  regbank_wr16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr     (clr),
    .busy    (busy),
    .clr_done(clr_done),
    .out     (out)
  );

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] model_out();
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[16*i +: 16] = mw[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mw[i] = '0;
    clr_left = 0;
  endtask

  // Called at a negedge: compare, drive, advance one edge.
  task automatic cycle(input logic v, input logic [3:0] a,
                       input logic [15:0] d, input logic c);
    bit acc;
    chk("out", out, model_out());
    chk("wr_ready", 256'(wr_ready), 256'(clr_left == 0));
    chk("busy", 256'(busy), 256'(clr_left != 0));
    chk("clr_done", 256'(clr_done), 256'(clr_left == 1));
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clr      = c;
    acc = v && (clr_left == 0);
    @(posedge clk);
    if (acc && a != 4'd0) mw[a] = d;
    if (clr_left > 0) begin
      mw[16 - clr_left] = '0;
      clr_left--;
    end else if (c) begin
      clr_left = 16;
    end
    @(negedge clk);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    tbl[0] = '{1'b1, 4'd5,  16'hA5A5, 4'd5,  16'hA5A5};
    tbl[1] = '{1'b1, 4'd0,  16'hFFFF, 4'd0,  16'h0000};
    tbl[2] = '{1'b1, 4'd5,  16'h1111, 4'd5,  16'h1111};
    tbl[3] = '{1'b1, 4'd5,  16'h2222, 4'd5,  16'h2222};
    tbl[4] = '{1'b0, 4'd6,  16'hDEAD, 4'd6,  16'h0000};
    tbl[5] = '{1'b1, 4'd15, 16'h8001, 4'd15, 16'h8001};

    rst_n = 1'b0;
    wr_valid = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr = 1'b0;
    model_reset();
    #12;
    chk("reset out", out, 256'd0);
    chk("reset busy", 256'(busy), 256'd0);
    chk("reset done", 256'(clr_done), 256'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      cycle(tbl[i].v, tbl[i].a, tbl[i].d, 1'b0);
      chk($sformatf("vec%0d word", i),
          256'(out[16*tbl[i].ca +: 16]), 256'(tbl[i].ce));
      chk($sformatf("vec%0d ready", i), 256'(wr_ready), 256'd1);
    end

    // fill 1..15, clear while a write to 3 is held off
    for (int k = 1; k < 16; k++) cycle(1'b1, 4'(k), 16'(k), 1'b0);
    cycle(1'b0, 4'd0, 16'd0, 1'b1);
    busy_cnt = 0;
    done_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      if (busy) busy_cnt++;
      if (clr_done) done_cnt++;
      chk("clr word9", 256'(out[159:144]),
          256'(j <= 9 ? 16'd9 : 16'd0));
      cycle(1'b1, 4'd3, 16'h1234, 1'b0);
    end
    chk("clr busy cycles", 256'(busy_cnt), 256'd16);
    chk("clr done pulses", 256'(done_cnt), 256'd1);
    chk("clr all zero", out, 256'd0);
    chk("clr idle ready", 256'(wr_ready), 256'd1);
    cycle(1'b1, 4'd3, 16'h1234, 1'b0);
    chk("held write", 256'(out[63:48]), 256'h1234);

    // same-cycle clear + write, second clear mid-sequence
    cycle(1'b1, 4'd10, 16'hBEEF, 1'b1);
    busy_cnt = 0;
    for (int j = 0; j < 16; j++) begin
      if (busy) busy_cnt++;
      chk("beef word10", 256'(out[175:160]),
          256'(j <= 10 ? 16'hBEEF : 16'h0000));
      cycle(1'b0, 4'd0, 16'd0, j == 5);
    end
    chk("beef busy cycles", 256'(busy_cnt), 256'd16);
    chk("beef busy end", 256'(busy), 256'd0);
    cycle(1'b0, 4'd0, 16'd0, 1'b0);

    // reset in the middle of a clear
    for (int k = 1; k < 16; k++) cycle(1'b1, 4'(k), ~16'(k), 1'b0);
    cycle(1'b0, 4'd0, 16'd0, 1'b1);
    for (int j = 0; j < 6; j++) cycle(1'b0, 4'd0, 16'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async out", out, 256'd0);
    chk("async busy", 256'(busy), 256'd0);
    chk("async done", 256'(clr_done), 256'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("post rst ready", 256'(wr_ready), 256'd1);
    for (int j = 0; j < 20; j++) cycle(1'b0, 4'd0, 16'd0, 1'b0);

    // random traffic
    for (int j = 0; j < 600; j++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            16'($urandom), $urandom_range(0, 24) == 0);
    end
    cycle(1'b0, 4'd0, 16'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
